rep_loop_counter: RTL and testbench
===================================

# rep_loop_counter

Parametrised iteration counter for microcode-driven repeat loops (REP/REPE/REPNE string operations, LOOP/LOOPZ/LOOPNZ, multi-step shifts). It generalises the fixed 5-bit down-counter to a WIDTH-bit count. It adds flag-conditioned early termination, interrupt suspension at iteration boundaries, abort, and a termination-cause report. It sits beside the microcode sequencer, which loads it, pulses `next` once per completed iteration, and branches on `done`/`suspended`.

## Interface
- `WIDTH`, default 16: width of the iteration count (CX-sized by default).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `count_in`  in  WIDTH  initial iteration count, captured on `load`.
- `mode_in`  in  2  captured on `load`: 00 plain, 01 REPE (stop when zf=0), 10 REPNE (stop when zf=1), 11 treated as plain.
- `load`  in  1  start a new loop.
- `next`  in  1  one iteration completed this cycle.
- `zf`  in  1  zero flag produced by this iteration; sampled only with `next`.
- `irq_pending`  in  1  interrupt waiting; honoured only at an iteration boundary.
- `resume`  in  1  continue a suspended loop.
- `abort`  in  1  terminate the loop immediately.
- `count`  out  WIDTH  remaining count (CX writeback value).
- `done`  out  1  no further iterations are to run.
- `running`  out  1  loop active, iterations outstanding.
- `suspended`  out  1  loop parked for interrupt; `count` valid for writeback.
- `cause`  out  2  termination cause: 00 none, 01 count reached zero, 10 flag condition, 11 abort.

## Operation
- State machine: IDLE, RUN, SUSP, DONE. Exactly one state is active. `running`=RUN, `suspended`=SUSP, `done`=IDLE|DONE.
- Priority per cycle: `reset` > `load` > `abort` > `next` > `resume`.
- `reset`: state=IDLE, `count`=0, latched mode=00, `cause`=00. Outputs: `done`=1, `running`=0, `suspended`=0.
- `load` (any state): `count`<=`count_in`, mode<=`mode_in`.
  - If `count_in`==0: go to DONE with `cause`=01. No iterations run.
  - Otherwise: go to RUN with `cause`=00.
- `abort` in RUN or SUSP: go to DONE with `cause`=11; `count` held. `abort` in IDLE or DONE is ignored.
- `next` in RUN: `count`<=`count`-1 (WIDTH-bit arithmetic; never wraps, because RUN implies `count`≠0). Then, evaluated on the decremented value:
  - Decremented value ==0: go to DONE, `cause`=01. Zero has priority over the flag.
  - Otherwise, REPE with `zf`=0, or REPNE with `zf`=1: go to DONE, `cause`=10.
  - Otherwise, `irq_pending`=1: go to SUSP.
  - Otherwise: stay in RUN.
- `next` in IDLE, SUSP or DONE: ignored; `count` unchanged.
- `resume` in SUSP: go to RUN; `count` and mode are held.
  - If `resume` and `next` both arrive in SUSP: `next` is ignored and the loop resumes.
  - `resume` in any other state: ignored.
- `irq_pending` outside a RUN+`next` cycle has no effect.
- DONE persists until `load` or `reset`. `count` remains readable in DONE.

## Timing
- All outputs are registered and change only on the edge after the causing input. There are no combinational input-to-output paths.
- `load` at edge N: `count`=`count_in` and `running`/`done` are valid from cycle N+1.
- `next` at edge N: the decremented `count` and the new state are visible at N+1. The sequencer may issue `next` on consecutive cycles (one iteration per clock).
- Loading `count_in`=K with `next` held high and no early termination gives `done`=1 exactly K cycles after `load` is sampled.
- A mid-operation `reset` discards the loop within one cycle. There is no residual suspend and no residual cause.

## Test plan
- Plain mode: `load` `count_in`=3, `next` high every cycle. Required: `count` sequence 3,2,1,0; `done` rises on the 3rd cycle after `load`; `cause`=01. Further `next` pulses leave `count`=0.
- `count_in`=0 on `load`. Required: next cycle `done`=1, `running`=0, `cause`=01. `next` is ignored.
- REPE: `load` 5. Apply `next` with `zf`=1,1,0. Required: DONE after the 3rd `next` with `count`=2, `cause`=10. Separately, REPNE with `load` 1 and `zf`=1: `count`=0, `cause`=01 (zero beats flag).
- Interrupt: `load` 4. Apply `next` with `irq_pending`=1. Required: `suspended`=1, `count`=3. A `next` during SUSP leaves `count`=3. `resume` returns to RUN; three more `next` pulses give `done` with `cause`=01.
- Abort and priority: from RUN with `count`=7, assert `abort`+`next` together. Required: `count`=7, `cause`=11. Then `load` 2 in the same cycle as `abort`: `load` wins and the counter is in RUN with `count`=2.
- Reset mid-loop: from SUSP with `count`=9, assert `reset`. Required: next cycle `count`=0, `done`=1, `suspended`=0, `cause`=00. WIDTH=5 instance: `load` 31 then 31 `next` pulses reach 0 without wrap.

Source files
------------

// File: rtl/rep_loop_counter.sv
// rep_loop_counter
//   Iteration counter for microcode-driven repeat loops (REP/REPE/REPNE,
//   LOOP/LOOPZ/LOOPNZ, multi-step shifts). The sequencer loads a count and a
//   mode, pulses `next` once per finished iteration, and branches on
//   `done` / `suspended`. The loop can end early on a flag condition, park
//   at an iteration boundary for an interrupt, or be aborted.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   count_in     in   WIDTH  initial iteration count, captured on load
//   mode_in      in   2      00 plain, 01 REPE, 10 REPNE, 11 plain
//   load         in   start a new loop
//   next         in   one iteration completed this cycle
//   zf           in   zero flag of this iteration (used only with next)
//   irq_pending  in   interrupt waiting (honoured only with next in RUN)
//   resume       in   continue a suspended loop
//   abort        in   terminate the loop immediately
//   count        out  WIDTH  remaining count (CX writeback value)
//   done         out  no further iterations are to run
//   running      out  loop active, iterations outstanding
//   suspended    out  loop parked for interrupt
//   cause        out  2      00 none, 01 zero, 10 flag, 11 abort
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.

module rep_loop_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic [1:0]       mode_in,
  input  logic             load,
  input  logic             next,
  input  logic             zf,
  input  logic             irq_pending,
  input  logic             resume,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             running,
  output logic             suspended,
  output logic [1:0]       cause
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_SUSP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] MODE_REPE   = 2'b01;
  localparam logic [1:0] MODE_REPNE  = 2'b10;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ZERO  = 2'b01;
  localparam logic [1:0] CAUSE_FLAG  = 2'b10;
  localparam logic [1:0] CAUSE_ABORT = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [1:0]       r_mode;
  logic [1:0]       r_cause;
  logic             r_done;
  logic             r_running;
  logic             r_suspended;

  logic [WIDTH-1:0] w_cnt_dec;
  logic             w_flag_stop;

  // REPE stops when the iteration cleared ZF, REPNE when it set ZF.
  // Mode 11 behaves as plain and never stops on the flag.
  function automatic logic flag_stop(input logic [1:0] mode, input logic flag);
    return ((mode == MODE_REPE) && !flag) || ((mode == MODE_REPNE) && flag);
  endfunction

  // Only consumed in RUN, where count is never zero, so this cannot wrap.
  assign w_cnt_dec   = r_count - WIDTH'(1);
  assign w_flag_stop = flag_stop(r_mode, zf);

  // Priority: reset > load > abort > next > resume.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_mode      <= 2'b00;
      r_cause     <= CAUSE_NONE;
      r_done      <= 1'b1;
      r_running   <= 1'b0;
      r_suspended <= 1'b0;
    end else if (load) begin
      r_count     <= count_in;
      r_mode      <= mode_in;
      r_suspended <= 1'b0;
      if (count_in == '0) begin
        // Zero-trip loop: finish without running an iteration.
        r_state   <= S_DONE;
        r_cause   <= CAUSE_ZERO;
        r_done    <= 1'b1;
        r_running <= 1'b0;
      end else begin
        r_state   <= S_RUN;
        r_cause   <= CAUSE_NONE;
        r_done    <= 1'b0;
        r_running <= 1'b1;
      end
    end else if (abort && (r_state == S_RUN || r_state == S_SUSP)) begin
      // Count is held so the sequencer can write back the partial CX.
      r_state     <= S_DONE;
      r_cause     <= CAUSE_ABORT;
      r_done      <= 1'b1;
      r_running   <= 1'b0;
      r_suspended <= 1'b0;
    end else if (next && r_state == S_RUN) begin
      r_count <= w_cnt_dec;
      // Exhausted count beats the flag; either termination beats the irq.
      if (w_cnt_dec == '0) begin
        r_state   <= S_DONE;
        r_cause   <= CAUSE_ZERO;
        r_done    <= 1'b1;
        r_running <= 1'b0;
      end else if (w_flag_stop) begin
        r_state   <= S_DONE;
        r_cause   <= CAUSE_FLAG;
        r_done    <= 1'b1;
        r_running <= 1'b0;
      end else if (irq_pending) begin
        r_state     <= S_SUSP;
        r_running   <= 1'b0;
        r_suspended <= 1'b1;
      end
    end else if (resume && r_state == S_SUSP) begin
      // A next arriving alongside resume in SUSP is deliberately dropped.
      r_state     <= S_RUN;
      r_running   <= 1'b1;
      r_suspended <= 1'b0;
    end
  end

  assign count     = r_count;
  assign done      = r_done;
  assign running   = r_running;
  assign suspended = r_suspended;
  assign cause     = r_cause;

endmodule

// File: tb/tb_rep_loop_counter.sv
// Bench for rep_loop_counter. Two instances (WIDTH=16 and WIDTH=5) share one
// input stream. The driver applies one cycle of stimulus, advances a
// behavioural model of each instance and queues the expected outputs; a
// monitor on the falling edge pops one entry per cycle and compares.

module tb_rep_loop_counter;

  logic        clk;
  logic        reset;
  logic [15:0] count_in;
  logic [1:0]  mode_in;
  logic        load, next, zf, irq_pending, resume, abort;

  logic [15:0] count16;
  logic        done16, running16, suspended16;
  logic [1:0]  cause16;
  logic [4:0]  count5;
  logic        done5, running5, suspended5;
  logic [1:0]  cause5;

  rep_loop_counter #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .count_in(count_in), .mode_in(mode_in),
    .load(load), .next(next), .zf(zf), .irq_pending(irq_pending),
    .resume(resume), .abort(abort), .count(count16), .done(done16),
    .running(running16), .suspended(suspended16), .cause(cause16)
  );

  rep_loop_counter #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .count_in(count_in[4:0]), .mode_in(mode_in),
    .load(load), .next(next), .zf(zf), .irq_pending(irq_pending),
    .resume(resume), .abort(abort), .count(count5), .done(done5),
    .running(running5), .suspended(suspended5), .cause(cause5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ld;
    logic        ab;
    logic        nx;
    logic        rs;
    logic        z;
    logic        irq;
    logic [15:0] cin;
    logic [1:0]  mode;
  } stim_t;

  // Loop abstraction: a loop is "live" between start and end; a live loop is
  // either iterating or parked. "left" is the number of iterations remaining.
  typedef struct {
    bit     live;
    bit     parked;
    longint left;
    bit [1:0] mode;
    bit [1:0] why;
  } model_t;

  typedef struct {
    logic [20:0] v16;   // {count, done, running, suspended, cause}
    logic [9:0]  v5;
  } exp_t;

  model_t m16, m5;
  exp_t   expq[$];
  int     checks   = 0;
  int     failures = 0;

  function automatic model_t step(input model_t m, input stim_t s, input int w);
    model_t r = m;
    longint mask = (longint'(1) << w) - 1;
    if (s.rst) begin
      r.live = 0; r.parked = 0; r.left = 0; r.mode = 0; r.why = 0;
    end else if (s.ld) begin
      r.left = longint'(s.cin) & mask;
      r.mode = s.mode;
      r.parked = 0;
      r.live = (r.left != 0);
      r.why  = (r.left == 0) ? 2'd1 : 2'd0;
    end else if (s.ab && r.live) begin
      r.live = 0; r.parked = 0; r.why = 2'd3;
    end else if (s.nx && r.live && !r.parked) begin
      r.left = r.left - 1;
      if (r.left == 0) begin
        r.live = 0; r.why = 2'd1;
      end else if ((r.mode == 2'd1 && !s.z) || (r.mode == 2'd2 && s.z)) begin
        r.live = 0; r.why = 2'd2;
      end else if (s.irq) begin
        r.parked = 1;
      end
    end else if (s.rs && r.live && r.parked) begin
      r.parked = 0;
    end
    return r;
  endfunction

  function automatic logic [20:0] pack16(input model_t m);
    return {16'(m.left), !m.live, m.live && !m.parked, m.live && m.parked, m.why};
  endfunction

  function automatic logic [9:0] pack5(input model_t m);
    return {5'(m.left), !m.live, m.live && !m.parked, m.live && m.parked, m.why};
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    reset = s.rst; load = s.ld; abort = s.ab; next = s.nx; resume = s.rs;
    zf = s.z; irq_pending = s.irq; count_in = s.cin; mode_in = s.mode;
    m16 = step(m16, s, 16);
    m5  = step(m5, s, 5);
    e.v16 = pack16(m16);
    e.v5  = pack5(m5);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    stim_t s = '0;
    drive(s);
  endtask

  task automatic do_reset();
    stim_t s = '0;
    s.rst = 1;
    drive(s);
  endtask

  task automatic do_load(input logic [15:0] c, input logic [1:0] md);
    stim_t s = '0;
    s.ld = 1; s.cin = c; s.mode = md;
    drive(s);
  endtask

  task automatic do_next(input logic z, input logic irq);
    stim_t s = '0;
    s.nx = 1; s.z = z; s.irq = irq;
    drive(s);
  endtask

  // Monitor: one queued expectation per clock, compared away from the edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if ({count16, done16, running16, suspended16, cause16} !== e.v16) begin
        failures++;
        $display("FAIL w16 t=%0t got cnt=%0d dn=%b rn=%b sp=%b ca=%b exp cnt=%0d dn=%b rn=%b sp=%b ca=%b",
                 $time, count16, done16, running16, suspended16, cause16,
                 e.v16[20:5], e.v16[4], e.v16[3], e.v16[2], e.v16[1:0]);
      end
      checks++;
      if ({count5, done5, running5, suspended5, cause5} !== e.v5) begin
        failures++;
        $display("FAIL w5 t=%0t got cnt=%0d dn=%b rn=%b sp=%b ca=%b exp cnt=%0d dn=%b rn=%b sp=%b ca=%b",
                 $time, count5, done5, running5, suspended5, cause5,
                 e.v5[9:5], e.v5[4], e.v5[3], e.v5[2], e.v5[1:0]);
      end
    end
  end

  initial begin
    stim_t s;
    m16 = '{0, 0, 0, 0, 0};
    m5  = '{0, 0, 0, 0, 0};
    s = '0;
    reset = 0; load = 0; abort = 0; next = 0; resume = 0;
    zf = 0; irq_pending = 0; count_in = 0; mode_in = 0;

    do_reset();
    idle_cycle();

    // Plain count 3 with next every cycle, then extra nexts at zero.
    do_load(16'd3, 2'b00);
    repeat (5) do_next(1'b0, 1'b0);

    // Zero-trip load; next afterwards is ignored.
    do_load(16'd0, 2'b00);
    do_next(1'b0, 1'b0);

    // REPE stops on zf=0 with count 2; REPNE with count 1: zero beats flag.
    do_load(16'd5, 2'b01);
    do_next(1'b1, 1'b0);
    do_next(1'b1, 1'b0);
    do_next(1'b0, 1'b0);
    do_load(16'd1, 2'b10);
    do_next(1'b1, 1'b0);

    // Interrupt park, ignored next while parked, resume, run to zero.
    do_load(16'd4, 2'b00);
    do_next(1'b0, 1'b1);
    do_next(1'b0, 1'b0);
    s = '0; s.rs = 1; s.nx = 1; drive(s);   // resume wins, next dropped
    repeat (3) do_next(1'b0, 1'b0);

    // Abort beats next; load beats abort.
    do_load(16'd7, 2'b00);
    s = '0; s.ab = 1; s.nx = 1; drive(s);
    s = '0; s.ab = 1; s.ld = 1; s.cin = 16'd2; drive(s);
    do_next(1'b0, 1'b0);

    // Reset while parked with count 9.
    do_load(16'd10, 2'b00);
    do_next(1'b0, 1'b1);
    do_reset();
    s = '0; s.rs = 1; drive(s);

    // Full-range count on the 5-bit instance: 31 iterations, no wrap.
    do_load(16'd31, 2'b00);
    repeat (33) do_next(1'b1, 1'b0);

    // Constrained random traffic.
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst  = ($urandom_range(0, 99) < 2);
      s.ld   = ($urandom_range(0, 99) < 8);
      s.ab   = ($urandom_range(0, 99) < 4);
      s.nx   = ($urandom_range(0, 99) < 70);
      s.rs   = ($urandom_range(0, 99) < 30);
      s.z    = ($urandom_range(0, 99) < 80);
      s.irq  = ($urandom_range(0, 99) < 15);
      s.mode = 2'($urandom_range(0, 3));
      s.cin  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      drive(s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
